// File: rtl/maxpool_pkg.sv
// Shared defaults, FSM state encoding and a counter-width helper for the
// maxpool4_seq window sequencer.
package maxpool_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int NUM_CH_DEF  = 16;
    localparam int POOL_DEF    = 5;
    localparam int NUM_WIN_DEF = 37;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_POOL = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    // Bits needed for a counter that runs 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/maxpool4_winbuf.sv
// POOL-slot window register file. Each accepted beat writes one slot for every
// channel; slot k of channel c lives at bits [(c*POOL + k)*DATA_W +: DATA_W].
module maxpool4_winbuf
    import maxpool_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int POOL   = POOL_DEF,
    parameter int IDX_W  = cnt_w(POOL_DEF)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [NUM_CH*DATA_W-1:0]      wr_data,
    output logic [NUM_CH*POOL*DATA_W-1:0] win
);

    logic [NUM_CH*POOL*DATA_W-1:0] win_q;
    logic [NUM_CH*POOL*DATA_W-1:0] win_d;

    // Scatter the incoming beat into slot wr_idx of every channel.
    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        win_d = win_q;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < POOL; k++) begin
                if (wr_en && (wr_idx == IDX_W'(k))) begin
                    win_d[(c*POOL + k)*DATA_W +: DATA_W] = wr_data[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Window storage; cleared by reset so an aborted frame leaves no stale slots.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: this buffer is flop-based and small, so it is reset like any other
        // state; a RAM-style array would normally be left unreset.
        if (!rst) begin
            win_q <= '0;
        end else begin
            // NOTE: sequential state is always updated with non-blocking assignments.
            win_q <= win_d;
        end
    end

    assign win = win_q;

endmodule

// File: rtl/maxpool4_seq.sv
// maxpool4_seq: gathers POOL beats of NUM_CH samples into a window, fires the
// external pooling layer for one cycle, registers its result and holds it until
// the consumer takes it; NUM_WIN windows make a frame.
// Optional feature: define MAXPOOL4_SEQ_STALL_CNT_EN to add the stall_cnt output,
// a saturating count of FILL cycles without in_valid and HOLD cycles without
// out_ready, cleared on start.
module maxpool4_seq
    import maxpool_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int POOL    = POOL_DEF,
    parameter int NUM_WIN = NUM_WIN_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH*DATA_W-1:0]      in_data,
    output logic                          pool_en,
    output logic [NUM_CH*POOL*DATA_W-1:0] pool_win,
    input  logic [NUM_CH*DATA_W-1:0]      pool_res,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CH*DATA_W-1:0]      out_data,
    output logic                          frame_done,
    output logic                          busy
`ifdef MAXPOOL4_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int BEAT_W = cnt_w(POOL);
    localparam int WIN_W  = cnt_w(NUM_WIN);

    state_e                     state_q, state_d;
    logic [BEAT_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic [WIN_W-1:0]           win_cnt_q, win_cnt_d;
    logic [NUM_CH*DATA_W-1:0]   out_data_q, out_data_d;
    logic                       in_ready_q, in_ready_d;
    logic                       pool_en_q, pool_en_d;
    logic                       out_valid_q, out_valid_d;
    logic                       frame_done_q, frame_done_d;
    logic                       busy_q, busy_d;
    logic                       in_hs;
    logic                       out_hs;

    assign in_hs  = in_valid && in_ready_q;
    assign out_hs = out_valid_q && out_ready;

    maxpool4_winbuf #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .POOL   (POOL),
        .IDX_W  (BEAT_W)
    ) u_winbuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_hs),
        .wr_idx  (beat_cnt_q),
        .wr_data (in_data),
        .win     (pool_win)
    );

    // Next state, counters and registered outputs (outputs decoded from the next state).
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        win_cnt_d    = win_cnt_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_hs) begin
                    if (beat_cnt_q == BEAT_W'(POOL - 1)) begin
                        beat_cnt_d = '0;
                        state_d    = ST_POOL;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end
            ST_POOL: begin
                // The window is frozen here, so pool_res is settled at this edge.
                out_data_d = pool_res;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_hs) begin
                    if (win_cnt_q == WIN_W'(NUM_WIN - 1)) begin
                        win_cnt_d    = '0;
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        state_d   = ST_FILL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_FILL);
        pool_en_d   = (state_d == ST_POOL);
        out_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
    end

    // Control state and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            win_cnt_q    <= '0;
            out_data_q   <= '0;
            in_ready_q   <= 1'b0;
            pool_en_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            win_cnt_q    <= win_cnt_d;
            out_data_q   <= out_data_d;
            in_ready_q   <= in_ready_d;
            pool_en_q    <= pool_en_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign pool_en    = pool_en_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

`ifdef MAXPOOL4_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count starved FILL cycles and back-pressured HOLD cycles, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_cnt_d = '0;
        end else if ((((state_q == ST_FILL) && !in_valid) ||
                      ((state_q == ST_HOLD) && !out_ready)) &&
                     (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_maxpool4_seq.sv
// Self-checking bench for maxpool4_seq. The pooling layer is modelled as a
// per-channel unsigned max over the window; expected results are built from the
// accepted beats, queued, and compared when the DUT hands a result out.
module tb_maxpool4_seq;

    localparam int DATA_W  = 8;
    localparam int NUM_CH  = 16;
    localparam int POOL    = 5;
    localparam int NUM_WIN = 37;
    localparam int IW      = NUM_CH*DATA_W;
    localparam int WW      = NUM_CH*POOL*DATA_W;
    localparam int NV      = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          pool_en;
    logic [WW-1:0] pool_win;
    logic [IW-1:0] pool_res;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_data;
    logic          frame_done;
    logic          busy;
`ifdef MAXPOOL4_SEQ_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    maxpool4_seq #(
        .DATA_W  (DATA_W),
        .NUM_CH  (NUM_CH),
        .POOL    (POOL),
        .NUM_WIN (NUM_WIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .pool_en    (pool_en),
        .pool_win   (pool_win),
        .pool_res   (pool_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef MAXPOOL4_SEQ_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // Pooling layer: per-channel unsigned max of the POOL slots.
    function automatic logic [IW-1:0] pool_max(input logic [WW-1:0] w);
        logic [IW-1:0]     r;
        logic [DATA_W-1:0] m;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m = w[(c*POOL)*DATA_W +: DATA_W];
            for (int k = 1; k < POOL; k++) begin
                if (w[(c*POOL + k)*DATA_W +: DATA_W] > m) m = w[(c*POOL + k)*DATA_W +: DATA_W];
            end
            r[c*DATA_W +: DATA_W] = m;
        end
        return r;
    endfunction

    assign pool_res = pool_max(pool_win);

    typedef struct {
        logic [DATA_W-1:0] ch0 [POOL];
        logic [DATA_W-1:0] exp_max;
    } vec_t;

    vec_t              vecs [NV];
    logic [DATA_W-1:0] ch0_vals [POOL];
    logic [IW-1:0]     exp_q [$];
    logic [IW-1:0]     acc;
    logic [IW-1:0]     last_out;
    int                acc_n;
    int                checks;
    int                errors;
    int                cyc_no;
    int                first_beat_cyc;
    int                pool_en_cnt;
    int                fd_cnt;
    int                frame_hs;
    int                stall_exp;
    bit                got_out;

    task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // One clock: account for handshakes about to happen, then move to the next negedge.
    task automatic advance();
        bit in_hs;
        bit out_hs;
        in_hs  = in_valid && in_ready;
        out_hs = out_valid && out_ready;
        if (pool_en) pool_en_cnt++;
        if (frame_done) fd_cnt++;
        if (start && !busy) stall_exp = 0;
        else if ((in_ready && !in_valid) || (out_valid && !out_ready)) stall_exp++;
        if (in_hs) begin
            if (acc_n == 0) begin
                acc            = in_data;
                first_beat_cyc = cyc_no;
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (in_data[c*DATA_W +: DATA_W] > acc[c*DATA_W +: DATA_W])
                        acc[c*DATA_W +: DATA_W] = in_data[c*DATA_W +: DATA_W];
                end
            end
            acc_n++;
            if (acc_n == POOL) begin
                exp_q.push_back(acc);
                acc_n = 0;
            end
        end
        if (out_hs) begin
            last_out = out_data;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got %0h expected no result", out_data);
            end else begin
                check("out_data", out_data, exp_q.pop_front());
            end
            frame_hs++;
            got_out = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc_no++;
    endtask

    // Drive one window and wait for its result to be taken.
    task automatic run_window(input bit rnd_valid, input bit rnd_ready, input int idle_fill,
                              input int hold_cyc, input bit spur_start, input bit chk_lat,
                              input bit use_ch0);
        logic [IW-1:0] beats [POOL];
        logic [IW-1:0] held;
        int            k;
        int            pe0;
        int            idle_left;
        int            hold_left;
        bit            seen_ov;
        bit            spur_done;
        bit            will_acc;
        for (int i = 0; i < POOL; i++) begin
            for (int c = 0; c < NUM_CH; c++) beats[i][c*DATA_W +: DATA_W] = DATA_W'($urandom);
            if (use_ch0) beats[i][DATA_W-1:0] = ch0_vals[i];
        end
        k = 0; pe0 = pool_en_cnt; idle_left = idle_fill; hold_left = hold_cyc;
        seen_ov = 1'b0; spur_done = 1'b0; got_out = 1'b0; held = '0;
        for (int budget = 0; budget < 400 && !got_out; budget++) begin
            if (in_ready && k < POOL) begin
                in_data = beats[k];
                if (idle_left > 0) begin
                    in_valid = 1'b0;
                    idle_left--;
                end else begin
                    in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end else begin
                in_valid = out_valid;
            end
            start = 1'b0;
            if (spur_start && !spur_done && in_ready && k == 2) begin
                start     = 1'b1;
                spur_done = 1'b1;
            end
            if (out_valid) begin
                if (!seen_ov) begin
                    seen_ov = 1'b1;
                    held    = out_data;
                    if (chk_lat) check("latency", cyc_no - first_beat_cyc + 1, POOL + 2);
                end
                if (hold_left > 0) begin
                    out_ready = 1'b0;
                    hold_left--;
                    check("hold_stable", out_data, held);
                    check("hold_in_ready", in_ready, 0);
                end else begin
                    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end else begin
                out_ready = 1'b0;
            end
            will_acc = in_valid && in_ready;
            advance();
            if (will_acc) k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        start     = 1'b0;
        if (!got_out) fail_now("window_timeout");
        check("pool_en_per_win", pool_en_cnt - pe0, 1);
    endtask

    task automatic do_start();
        frame_hs = 0;
        fd_cnt   = 0;
        start    = 1'b1;
        advance();
        start    = 1'b0;
        check("start_busy", busy, 1);
        check("start_in_ready", in_ready, 1);
    endtask

    task automatic finish_frame(input bit rnd);
        for (int w = 0; w < NUM_WIN + 4 && frame_hs < NUM_WIN; w++) run_window(rnd, rnd, 0, 0, 0, 0, 0);
        check("frame_hs", frame_hs, NUM_WIN);
        check("fd_early", fd_cnt, 0);
        check("frame_done_pulse", frame_done, 1);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);
        advance();
        check("frame_done_clear", frame_done, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_pool_en"}, pool_en, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_pool_win"}, |pool_win, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0].ch0 = '{8'd3, 8'd9, 8'd1, 8'd7, 8'd2};        vecs[0].exp_max = 8'd9;
        vecs[1].ch0 = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};        vecs[1].exp_max = 8'd0;
        vecs[2].ch0 = '{8'd255, 8'd1, 8'd2, 8'd3, 8'd4};      vecs[2].exp_max = 8'd255;
        vecs[3].ch0 = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd254};      vecs[3].exp_max = 8'd254;
        vecs[4].ch0 = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd10};   vecs[4].exp_max = 8'd10;

        checks = 0; errors = 0; cyc_no = 0; acc_n = 0; acc = '0; last_out = '0;
        pool_en_cnt = 0; fd_cnt = 0; frame_hs = 0; stall_exp = 0; got_out = 1'b0;
        first_beat_cyc = 0;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b1;
        advance();
        check("idle_after_rst", busy, 0);

        // Frame 1: table vectors with in_valid held high, then corner windows.
        do_start();
        for (int v = 0; v < NV; v++) begin
            ch0_vals = vecs[v].ch0;
            run_window(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
            check("vec_ch0_max", last_out[DATA_W-1:0], vecs[v].exp_max);
        end
        run_window(1'b0, 1'b0, 0, 10, 1'b0, 1'b0, 1'b0);
        run_window(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        check("spur_start_busy", busy, 1);
        finish_frame(1'b1);

        // Frame 2: stall accounting, then random back-pressure to the end.
        do_start();
`ifdef MAXPOOL4_SEQ_STALL_CNT_EN
        run_window(1'b0, 1'b0, 4, 2, 1'b0, 1'b0, 1'b0);
        check("stall_cnt_6", stall_cnt, 6);
`endif
        finish_frame(1'b1);
`ifdef MAXPOOL4_SEQ_STALL_CNT_EN
        check("stall_cnt_frame", stall_cnt, stall_exp);
`endif

        // Frame 3: abort with reset after three beats, then a clean window.
        do_start();
        in_valid = 1'b1;
        in_data  = {NUM_CH{8'hF0}};
        for (int i = 0; i < 3; i++) advance();
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check_all_zero("mid_rst");
        acc_n = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            advance();
            check("no_partial_out", out_valid, 0);
        end
        do_start();
        ch0_vals = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd0};
        run_window(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        check("post_rst_ch0", last_out[DATA_W-1:0], 3);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
